toi2s_i2s_tx: RTL and testbench
===============================

// Module: toi2s_i2s_tx
// PURPOSE
// - I2S serializer: takes stereo PCM sample pairs over a valid/ready handshake and drives bck/ws/d0 to the external amplifier.
// - Sits between the sample producer of the receive path and the amp_i2s_* pins; it is the amplifier-facing output stage.
// - Has a one-entry holding buffer so the producer can deliver the next pair while the current frame shifts out.
// PARAMETERS
// DATA_W   16  sample width per channel; bits are sent MSB first.
// SLOT_W   16  bck cycles per channel slot; must be >= DATA_W. Slot bits after the LSB are 0.
// BCK_DIV  4   clk cycles per bck half-period; must be >= 1.
// PORTS
// clk        in   1       system clock
// resetb     in   1       synchronous reset, active low
// ena        in   1       block enable; 0 = idle and flush
// s_valid    in   1       sample pair valid
// s_ready    out  1       holding buffer can accept a pair
// s_left     in   DATA_W  left sample (two's complement)
// s_right    in   DATA_W  right sample
// i2s_bck    out  1       bit clock
// i2s_ws     out  1       word select: 0 = left, 1 = right
// i2s_d0     out  1       serial data
// underrun   out  1       1-clk pulse: frame started with no sample buffered
// running    out  1       1 while state is RUN
// BEHAVIOUR
// - Reset (resetb=0 at a clk edge): state IDLE, buffer empty, counters 0.
//   i2s_bck, i2s_ws, i2s_d0, underrun, running and s_ready are all 0.
// - All outputs are registered. A transfer happens when s_valid & s_ready are both 1 at a clk edge.
// - s_ready = (state != IDLE) & ~buf_full. s_ready is registered, so a write never collides with a full buffer.
// - FSM:
//   IDLE: ena=1 -> WAIT.
//   WAIT: s_ready=1; the I2S outputs stay 0. The first transfer goes straight to the active frame register and enters RUN
//         with p=0, div_cnt=0, bck=0, ws=0, d0=0.
//   RUN:  ena=0 -> IDLE. It never leaves RUN on underrun.
//   Any state with ena=0 -> IDLE on the next clk: outputs 0, buffer flushed, counters 0.
// - Bit clock: div_cnt counts 0..BCK_DIV-1. At the wrap, bck toggles, so the bck period is 2*BCK_DIV clk.
//   bck is low for the first BCK_DIV clk after RUN entry.
// - Frame position p counts 0..2*SLOT_W-1. It advances only on the clk where bck goes 1->0 (the falling edge).
//   ws and d0 update on that same clk.
// - Frame bit k:
//   k < SLOT_W:  s_left[DATA_W-1-k] if k < DATA_W, else 0.
//   k >= SLOT_W: the same rule applied to s_right with k-SLOT_W.
// - I2S one-bit delay:
//   ws during p is 0 for p < SLOT_W, else 1.
//   d0 during p is frame bit p-1. At p=0 it is bit 2*SLOT_W-1 of the previous frame (0 for the first frame).
// - Frame wrap is the falling edge where p goes from 2*SLOT_W-1 to 0.
//   Buffer full: active <= buffer, buffer empties, s_ready rises on the next clk.
//   Buffer empty: active <= all zeros and underrun pulses for 1 clk.
//   A transfer on the same clk as the wrap fills the buffer and is not used for this frame.
// - Frame period = 4*SLOT_W*BCK_DIV clk (256 at defaults). Sustained throughput is one pair per frame.
// - resetb low or ena low mid-frame aborts immediately. No partial-frame completion; the buffered sample is lost.
// TESTING
// - Reset: hold resetb=0 for 3 clk with ena=1 and s_valid=1 -> all outputs 0 and no transfer. Release -> WAIT with s_ready=1.
// - Single frame (defaults): L=16'hA5F0, R=16'h0F0F -> bck period 8 clk; ws=0 for p=0..15 and 1 for p=16..31.
//   d0 at p=1..16 = 1010_0101_1111_0000, then p=17..32 = 0000_1111_0000_1111.
// - Streaming: hold s_valid=1 with an incrementing pattern for 8 frames.
//   -> every pair appears once, in order; no underrun; s_ready low for 255 of every 256 clk.
// - Underrun: supply 1 pair then drop s_valid -> next frame all-zero d0 and a 1-clk underrun pulse at the wrap.
//   A new pair then plays in the following frame.
// - Abort: drop ena at p=7 of a frame -> next clk bck=ws=d0=0, running=0, s_ready=0.
//   Re-enable -> WAIT; the old buffered pair is not replayed.
// - Padding: SLOT_W=24, DATA_W=16, L=16'hFFFF -> d0=1 for p=1..16 and 0 for p=17..24; ws rises at p=24; frame is 384 clk.

Source files
------------

// File: rtl/toi2s_i2s_tx.sv
// toi2s_i2s_tx: I2S serializer for the amplifier output pins.
// Stereo PCM pairs arrive over valid/ready; a one-pair buffer feeds the active frame.
module toi2s_i2s_tx #(
    parameter int DATA_W  = 16,
    parameter int SLOT_W  = 16,
    parameter int BCK_DIV = 4
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              ena,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              i2s_bck,
    output logic              i2s_ws,
    output logic              i2s_d0,
    output logic              underrun,
    output logic              running
);
    localparam int FW = 2 * SLOT_W;
    localparam int PW = $clog2(FW);
    localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(FW - 1);
    localparam logic [PW-1:0] P_RIGHT = PW'(SLOT_W);
    localparam logic [DW-1:0] D_LAST  = DW'(BCK_DIV - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RUN} state_t;

    state_t            state;
    logic [DATA_W-1:0] act_l;
    logic [DATA_W-1:0] act_r;
    logic [DATA_W-1:0] buf_l;
    logic [DATA_W-1:0] buf_r;
    logic              buf_full;
    logic              buf_full_n;
    logic [DW-1:0]     div_cnt;
    logic [PW-1:0]     p;
    logic [PW-1:0]     p_n;
    logic [FW-1:0]     frame;
    logic              xfer;
    logic              fall;
    logic              wrap;

    // Frame bit k sits at frame[FW-1-k]; slot padding stays zero.
    always_comb begin
        frame = '0;
        frame[FW-1 -: DATA_W]     = act_l;
        frame[SLOT_W-1 -: DATA_W] = act_r;
    end

    assign xfer = s_valid & s_ready;
    assign fall = (state == RUN) && (div_cnt == D_LAST) && i2s_bck;
    assign wrap = fall && (p == P_LAST);
    assign p_n  = wrap ? '0 : p + PW'(1);

    always_comb begin
        buf_full_n = buf_full;
        if (wrap && buf_full) begin
            buf_full_n = 1'b0;
        end else if (xfer) begin
            buf_full_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb || !ena) begin
            state    <= IDLE;
            act_l    <= '0;
            act_r    <= '0;
            buf_l    <= '0;
            buf_r    <= '0;
            buf_full <= 1'b0;
            div_cnt  <= '0;
            p        <= '0;
            i2s_bck  <= 1'b0;
            i2s_ws   <= 1'b0;
            i2s_d0   <= 1'b0;
            underrun <= 1'b0;
            running  <= 1'b0;
            s_ready  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            unique case (state)
                IDLE: begin
                    state   <= WAIT;
                    s_ready <= 1'b1;
                end
                WAIT: begin
                    if (xfer) begin
                        act_l   <= s_left;
                        act_r   <= s_right;
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (div_cnt == D_LAST) begin
                        div_cnt <= '0;
                        i2s_bck <= ~i2s_bck;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                    // One-bit I2S delay: d0 carries the bit of the position just left.
                    if (fall) begin
                        p      <= p_n;
                        i2s_ws <= (p_n >= P_RIGHT);
                        i2s_d0 <= frame[P_LAST - p];
                    end
                    if (wrap) begin
                        act_l    <= buf_full ? buf_l : '0;
                        act_r    <= buf_full ? buf_r : '0;
                        underrun <= ~buf_full;
                    end
                    if (xfer) begin
                        buf_l <= s_left;
                        buf_r <= s_right;
                    end
                    buf_full <= buf_full_n;
                    s_ready  <= ~buf_full_n;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_toi2s_i2s_tx.sv
// tb_toi2s_i2s_tx: scoreboard bench for the I2S serializer.
// Two instances (16-bit and 24-bit slots) share one stimulus stream.
module tb_toi2s_i2s_tx;
    localparam int B = 4;

    logic        clk = 1'b0;
    logic        resetb;
    logic        ena;
    logic        s_valid;
    logic [15:0] s_left;
    logic [15:0] s_right;
    logic [1:0]  rdy;
    logic [1:0]  bck;
    logic [1:0]  ws;
    logic [1:0]  d0;
    logic [1:0]  und;
    logic [1:0]  run;

    always #5 clk = ~clk;

    toi2s_i2s_tx #(.DATA_W(16), .SLOT_W(16), .BCK_DIV(B)) dut0 (
        .clk(clk), .resetb(resetb), .ena(ena),
        .s_valid(s_valid), .s_ready(rdy[0]),
        .s_left(s_left), .s_right(s_right),
        .i2s_bck(bck[0]), .i2s_ws(ws[0]), .i2s_d0(d0[0]),
        .underrun(und[0]), .running(run[0])
    );

    toi2s_i2s_tx #(.DATA_W(16), .SLOT_W(24), .BCK_DIV(B)) dut1 (
        .clk(clk), .resetb(resetb), .ena(ena),
        .s_valid(s_valid), .s_ready(rdy[1]),
        .s_left(s_left), .s_right(s_right),
        .i2s_bck(bck[1]), .i2s_ws(ws[1]), .i2s_d0(d0[1]),
        .underrun(und[1]), .running(run[1])
    );

    typedef struct {
        int          inst;
        logic [15:0] l;
        logic [15:0] r;
        int          acc;
    } ent_t;

    ent_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          ncyc = 0;
    int          mst[2] = '{0, 0};
    int          el[2] = '{0, 0};
    logic [15:0] cl[2];
    logic [15:0] cr[2];
    logic        plast[2];

    function automatic int slot(input int i);
        return (i == 0) ? 16 : 24;
    endfunction

    // Frame bit k: left slot then right slot, MSB first, zero padded.
    function automatic logic fbit(input int s, input logic [15:0] l,
                                  input logic [15:0] r, input int k);
        logic [15:0] w;
        int j;
        w = (k < s) ? l : r;
        j = (k < s) ? k : k - s;
        if (j >= 16) return 1'b0;
        return w[4'(15 - j)];
    endfunction

    function automatic int find(input int i);
        for (int n = 0; n < sb.size(); n++)
            if (sb[n].inst == i) return n;
        return -1;
    endfunction

    function automatic int cnt(input int i);
        int c;
        c = 0;
        for (int n = 0; n < sb.size(); n++)
            if (sb[n].inst == i) c++;
        return c;
    endfunction

    task automatic flush(input int i);
        for (int n = sb.size() - 1; n >= 0; n--)
            if (sb[n].inst == i) sb.delete(n);
    endtask

    task automatic monitor(input int i);
        int s, fr, fpos, fidx, p, k;
        logic e_bck, e_ws, e_d0, e_und, e_run, e_rdy;
        logic [5:0] exp_v, got_v;
        s = slot(i);
        fr = 4 * s * B;
        {e_bck, e_ws, e_d0, e_und, e_run, e_rdy} = '0;
        if (mst[i] == 1) e_rdy = 1'b1;
        if (mst[i] == 2) begin
            fpos = el[i] % fr;
            fidx = el[i] / fr;
            if (fpos == 0) begin
                k = find(i);
                if (fidx == 0) begin
                    checks++;
                    if (k < 0 || sb[k].acc != ncyc - 1) begin
                        failures++;
                        $display("FAIL first_pair inst=%0d cyc=%0d got_idx=%0d required=buffered", i, ncyc, k);
                    end
                    plast[i] = 1'b0;
                    if (k >= 0) begin
                        cl[i] = sb[k].l;
                        cr[i] = sb[k].r;
                        sb.delete(k);
                    end else begin
                        cl[i] = '0;
                        cr[i] = '0;
                    end
                end else begin
                    plast[i] = fbit(s, cl[i], cr[i], 2 * s - 1);
                    if (k >= 0 && sb[k].acc < ncyc - 1) begin
                        cl[i] = sb[k].l;
                        cr[i] = sb[k].r;
                        sb.delete(k);
                    end else begin
                        cl[i] = '0;
                        cr[i] = '0;
                        e_und = 1'b1;
                    end
                end
            end
            p = (el[i] / (2 * B)) % (2 * s);
            e_bck = ((el[i] / B) % 2) == 1;
            e_ws  = (p >= s);
            e_d0  = (p == 0) ? plast[i] : fbit(s, cl[i], cr[i], p - 1);
            e_run = 1'b1;
            e_rdy = (cnt(i) == 0);
        end
        exp_v = {e_bck, e_ws, e_d0, e_und, e_run, e_rdy};
        got_v = {bck[i], ws[i], d0[i], und[i], run[i], rdy[i]};
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL outputs inst=%0d cyc=%0d bck,ws,d0,und,run,rdy got=%b required=%b",
                     i, ncyc, got_v, exp_v);
        end
        // Advance the reference state across the coming clk edge.
        if (!resetb || !ena) begin
            mst[i] = 0;
            flush(i);
        end else if (mst[i] == 0) begin
            mst[i] = 1;
        end else if (mst[i] == 1) begin
            if (s_valid) begin
                mst[i] = 2;
                el[i] = 0;
            end
        end else begin
            el[i]++;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            for (int i = 0; i < 2; i++) monitor(i);
        end
    end

    task automatic tick(output logic h0);
        logic h1;
        @(negedge clk);
        h0 = s_valid & rdy[0];
        h1 = s_valid & rdy[1];
        @(posedge clk);
        if (h0) sb.push_back('{0, s_left, s_right, ncyc});
        if (h1) sb.push_back('{1, s_left, s_right, ncyc});
        #1;
    endtask

    task automatic ticks(input int n);
        logic h;
        for (int c = 0; c < n; c++) tick(h);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        logic h;
        int   c;
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        h = 1'b0;
        c = 0;
        while (!h && c < 3000) begin
            tick(h);
            c++;
        end
        checks++;
        if (!h) begin
            failures++;
            $display("FAIL handshake got=timeout required=accept within 3000 clk");
        end
    endtask

    initial begin
        logic [15:0] base;
        logic        h;
        int          c;
        resetb  = 1'b0;
        ena     = 1'b1;
        s_valid = 1'b1;
        s_left  = 16'($urandom);
        s_right = 16'($urandom);
        ticks(3);
        s_valid = 1'b0;
        resetb  = 1'b1;
        ticks(3);

        send(16'hA5F0, 16'h0F0F);
        s_valid = 1'b0;
        ticks(420);
        send(16'($urandom), 16'($urandom));
        s_valid = 1'b0;
        ticks(900);

        base = 16'($urandom);
        for (int n = 0; n < 10; n++) send(base + 16'(n), ~(base + 16'(n)));
        s_valid = 1'b0;

        c = 0;
        while (!(mst[0] == 2 && ((el[0] / (2 * B)) % 32) == 7) && c < 600) begin
            tick(h);
            c++;
        end
        checks++;
        if (c >= 600) begin
            failures++;
            $display("FAIL abort_point got=timeout required=p=7 within 600 clk");
        end
        ena = 1'b0;
        ticks(4);
        ena = 1'b1;
        ticks(20);
        send(16'($urandom), 16'($urandom));
        s_valid = 1'b0;
        ticks(700);

        for (int n = 0; n < 4000; n++) begin
            if (n % 1500 == 1000) begin
                s_valid = 1'b0;
                ena = 1'b0;
                ticks(3);
                ena = 1'b1;
            end
            if (!s_valid && $urandom_range(0, 99) < 3) begin
                s_valid = 1'b1;
                s_left  = 16'($urandom);
                s_right = 16'($urandom);
            end
            tick(h);
            if (h) s_valid = 1'b0;
        end
        s_valid = 1'b0;
        ticks(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
